// File: rtl/tensor_cpu_seq.sv
// rtl/tensor_cpu_seq.sv - scalar/tensor CPU with sequential N x N matrix-multiply engine
//
// Ports:
//   clock_in            sole clock, rising edge
//   reset_in            synchronous active-high reset
//   current_instruction [31:24] dst/taddr, [23:16] src1/imm, [15:8] src2, [7:0] opcode
//   instr_valid_in      instruction present
//   instr_ready_out     block can accept (IDLE and not in reset)
//   cpu_output          last scalar value written
//   output_valid_out    one-cycle pulse when cpu_output updates
//   busy_out            matmul in progress
//   done_out            one-cycle pulse when a matmul completes
//
// Optional feature: define TENSOR_ACCUMULATE_EN to make MATMUL accumulate into C
// (C += A*B) instead of overwriting it.

module tensor_cpu_seq #(
    parameter int WIDTH    = 8,
    parameter int N        = 4,
    parameter int NUM_REGS = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic [31:0]      current_instruction,
    input  logic             instr_valid_in,
    output logic             instr_ready_out,
    output logic [WIDTH-1:0] cpu_output,
    output logic             output_valid_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int TSIZE   = 3 * N * N;
    localparam int TADDR_W = $clog2(TSIZE);
    localparam int RIDX_W  = $clog2(NUM_REGS);
    localparam int CNT_W   = $clog2(N);

    localparam logic [7:0] OP_ADD    = 8'd0;
    localparam logic [7:0] OP_SUB    = 8'd1;
    localparam logic [7:0] OP_AND    = 8'd2;
    localparam logic [7:0] OP_OR     = 8'd3;
    localparam logic [7:0] OP_LI     = 8'd4;
    localparam logic [7:0] OP_ADDI   = 8'd5;
    localparam logic [7:0] OP_TLOAD  = 8'd6;
    localparam logic [7:0] OP_TREAD  = 8'd7;
    localparam logic [7:0] OP_MATMUL = 8'd8;

    typedef enum logic {IDLE, MAT} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] tens [TSIZE];

    logic [CNT_W-1:0] row, col;

    logic [7:0] f_dst, f_src1, f_src2, f_op;
    logic [WIDTH-1:0] imm, rd1, rd2, tread_val;
    logic [WIDTH-1:0] result;
    logic             scalar_wr;
    logic             accept;
    logic             last_elem;
    logic             t_wr_in_range, t_rd_in_range;
    logic [WIDTH-1:0] mac;
    logic [WIDTH-1:0] c_val;
    logic [TADDR_W-1:0] c_idx, a_idx, b_idx;

    assign f_dst  = current_instruction[31:24];
    assign f_src1 = current_instruction[23:16];
    assign f_src2 = current_instruction[15:8];
    assign f_op   = current_instruction[7:0];

    assign imm = WIDTH'(f_src1);
    assign rd1 = regs[f_src1[RIDX_W-1:0]];
    assign rd2 = regs[f_src2[RIDX_W-1:0]];

    // Addresses at or beyond 3*N*N are dead: writes dropped, reads yield zero.
    assign t_wr_in_range = int'(f_dst)  < TSIZE;
    assign t_rd_in_range = int'(f_src1) < TSIZE;
    assign tread_val     = t_rd_in_range ? tens[f_src1[TADDR_W-1:0]] : '0;

    assign instr_ready_out = (state == IDLE) && !reset_in;
    assign accept          = instr_valid_in && instr_ready_out;
    assign busy_out        = (state == MAT);
    assign last_elem       = (row == CNT_W'(N - 1)) && (col == CNT_W'(N - 1));

    always_comb begin
        result    = '0;
        scalar_wr = 1'b1;
        case (f_op)
            OP_ADD:   result = rd1 + rd2;
            OP_SUB:   result = rd1 - rd2;
            OP_AND:   result = rd1 & rd2;
            OP_OR:    result = rd1 | rd2;
            OP_LI:    result = imm;
            OP_ADDI:  result = rd2 + imm;
            OP_TREAD: result = tread_val;
            default:  scalar_wr = 1'b0;
        endcase
    end

    // Dot product of row `row` of A with column `col` of B, truncated to WIDTH.
    always_comb begin
        mac   = '0;
        a_idx = '0;
        b_idx = '0;
        for (int k = 0; k < N; k++) begin
            a_idx = TADDR_W'(int'(row) * N + k);
            b_idx = TADDR_W'(N * N + k * N + int'(col));
            mac   = mac + WIDTH'(tens[a_idx] * tens[b_idx]);
        end
    end

    assign c_idx = TADDR_W'(2 * N * N + int'(row) * N + int'(col));

`ifdef TENSOR_ACCUMULATE_EN
    assign c_val = tens[c_idx] + mac;
`else
    assign c_val = mac;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && f_op == OP_MATMUL) state_next = MAT;
            MAT:     if (last_elem) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            for (int t = 0; t < TSIZE; t++)    tens[t] <= '0;
            row              <= '0;
            col              <= '0;
            cpu_output       <= '0;
            output_valid_out <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            output_valid_out <= 1'b0;
            done_out         <= 1'b0;
            if (accept && scalar_wr) begin
                regs[f_dst[RIDX_W-1:0]] <= result;
                cpu_output              <= result;
                output_valid_out        <= 1'b1;
            end
            if (accept && f_op == OP_TLOAD && t_wr_in_range)
                tens[f_dst[TADDR_W-1:0]] <= imm;
            // No instruction is accepted in MAT, so this never collides with TLOAD.
            if (state == MAT) begin
                tens[c_idx] <= c_val;
                if (last_elem) begin
                    row      <= '0;
                    col      <= '0;
                    done_out <= 1'b1;
                end else if (col == CNT_W'(N - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tensor_cpu_seq.sv
// tb/tb_tensor_cpu_seq.sv - directed self-checking bench for tensor_cpu_seq

module tb_tensor_cpu_seq;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [31:0] current_instruction = '0;
    logic        instr_valid_in = 1'b0;
    logic        instr_ready_out;
    logic [7:0]  cpu_output;
    logic        output_valid_out;
    logic        busy_out;
    logic        done_out;

    int vectors = 0;
    int miscompares = 0;

    tensor_cpu_seq #(.WIDTH(8), .N(4), .NUM_REGS(16)) dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .current_instruction (current_instruction),
        .instr_valid_in      (instr_valid_in),
        .instr_ready_out     (instr_ready_out),
        .cpu_output          (cpu_output),
        .output_valid_out    (output_valid_out),
        .busy_out            (busy_out),
        .done_out            (done_out)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [31:0] enc(input int d, input int s1, input int s2, input int op);
        return {8'(d), 8'(s1), 8'(s2), 8'(op)};
    endfunction

    task automatic issue(input logic [31:0] ins);
        @(negedge clock_in);
        current_instruction = ins;
        instr_valid_in = 1'b1;
        @(posedge clock_in);
        #1;
        instr_valid_in = 1'b0;
    endtask

    // Issue a scalar op and check the value and pulse it produces.
    task automatic scalar(input string name, input logic [31:0] ins, input logic [7:0] exp);
        issue(ins);
        vectors++;
        if (cpu_output !== exp || output_valid_out !== 1'b1) begin
            $display("FAIL %s: cpu_output=%0h valid=%b, expected %0h valid=1", name, cpu_output, output_valid_out, exp);
            miscompares++;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clock_in);
            #1;
            if (done_out === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            $display("FAIL %s: done_out=0 after 40 cycles, expected pulse", name);
            miscompares++;
        end
    endtask

    task automatic test_reset;
        reset_in = 1'b1;
        repeat (2) @(posedge clock_in);
        #1;
        vectors++;
        if (instr_ready_out !== 1'b0) begin
            $display("FAIL reset_ready: got %b expected 0", instr_ready_out);
            miscompares++;
        end
        vectors++;
        if ({cpu_output, output_valid_out, busy_out, done_out} !== 11'd0) begin
            $display("FAIL reset_outputs: cpu=%0h v=%b busy=%b done=%b expected all 0",
                     cpu_output, output_valid_out, busy_out, done_out);
            miscompares++;
        end
        @(negedge clock_in);
        reset_in = 1'b0;
        #1;
        vectors++;
        if (instr_ready_out !== 1'b1) begin
            $display("FAIL ready_after_reset: got %b expected 1", instr_ready_out);
            miscompares++;
        end
    endtask

    task automatic test_scalar;
        scalar("li_r1", enc(1, 5, 0, 4), 8'h05);
        scalar("li_r2", enc(2, 3, 0, 4), 8'h03);
        scalar("sub_r3", enc(3, 1, 2, 1), 8'h02);
        scalar("sub_r4", enc(4, 2, 1, 1), 8'hFE);
        @(posedge clock_in);
        #1;
        vectors++;
        if (output_valid_out !== 1'b0 || cpu_output !== 8'hFE) begin
            $display("FAIL idle_hold: valid=%b cpu=%0h expected valid=0 cpu=fe", output_valid_out, cpu_output);
            miscompares++;
        end
        scalar("add_r5", enc(5, 1, 2, 0), 8'h08);
        scalar("and_r6", enc(6, 1, 2, 2), 8'h01);
        scalar("or_r7", enc(7, 1, 2, 3), 8'h07);
        scalar("addi_r8", enc(8, 8'h10, 2, 5), 8'h13);
        scalar("li_mod_r1", enc(8'h11, 9, 0, 4), 8'h09);
        scalar("add_r9", enc(9, 1, 0, 0), 8'h09);
        scalar("addi_wrap", enc(10, 8'hFF, 4, 5), 8'hFD);
    endtask

    task automatic test_matmul;
        for (int a = 0; a < 4; a++) issue(enc(a * 4 + a, 1, 0, 6));
        for (int m = 0; m < 16; m++) issue(enc(16 + m, m + 1, 0, 6));
        issue(enc(0, 0, 0, 8));
        vectors++;
        if (busy_out !== 1'b1 || instr_ready_out !== 1'b0 || done_out !== 1'b0) begin
            $display("FAIL mm_start: busy=%b ready=%b done=%b expected 1 0 0", busy_out, instr_ready_out, done_out);
            miscompares++;
        end
        for (int c = 1; c <= 16; c++) begin
            @(posedge clock_in);
            #1;
            if (c < 16) begin
                vectors++;
                if (busy_out !== 1'b1 || done_out !== 1'b0 || instr_ready_out !== 1'b0) begin
                    $display("FAIL mm_run_%0d: busy=%b done=%b ready=%b expected 1 0 0", c, busy_out, done_out, instr_ready_out);
                    miscompares++;
                end
            end else begin
                vectors++;
                if (busy_out !== 1'b0 || done_out !== 1'b1 || instr_ready_out !== 1'b1) begin
                    $display("FAIL mm_end: busy=%b done=%b ready=%b expected 0 1 1", busy_out, done_out, instr_ready_out);
                    miscompares++;
                end
            end
        end
        @(posedge clock_in);
        #1;
        vectors++;
        if (done_out !== 1'b0) begin
            $display("FAIL mm_done_pulse: done=%b expected 0", done_out);
            miscompares++;
        end
        scalar("tread_c33", enc(10, 47, 0, 7), 8'd16);
        scalar("tread_c00", enc(10, 32, 0, 7), 8'd1);
        scalar("tread_c12", enc(10, 38, 0, 7), 8'd7);
    endtask

    task automatic test_accumulate;
        logic [7:0] exp;
`ifdef TENSOR_ACCUMULATE_EN
        exp = 8'd32;
`else
        exp = 8'd16;
`endif
        issue(enc(0, 0, 0, 8));
        wait_done("acc_done");
        scalar("acc_c33", enc(10, 47, 0, 7), exp);
    endtask

    task automatic test_back_to_back_hold;
        int pulses = 0;
        bit seen = 0;
        issue(enc(0, 0, 0, 8));
        @(negedge clock_in);
        current_instruction = enc(11, 1, 11, 5);
        instr_valid_in = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clock_in);
            #1;
            if (output_valid_out === 1'b1) pulses++;
            if (done_out === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen || pulses != 0) begin
            $display("FAIL hold_not_consumed: done_seen=%b pulses=%0d expected 1 and 0", seen, pulses);
            miscompares++;
        end
        @(posedge clock_in);
        #1;
        instr_valid_in = 1'b0;
        vectors++;
        if (output_valid_out !== 1'b1 || cpu_output !== 8'd1) begin
            $display("FAIL hold_exec: valid=%b cpu=%0h expected 1 and 1", output_valid_out, cpu_output);
            miscompares++;
        end
        @(posedge clock_in);
        #1;
        vectors++;
        if (output_valid_out !== 1'b0) begin
            $display("FAIL hold_once_pulse: valid=%b expected 0", output_valid_out);
            miscompares++;
        end
        scalar("hold_once_val", enc(12, 11, 0, 0), 8'd1);
    endtask

    task automatic test_reset_mid_matmul;
        issue(enc(0, 0, 0, 8));
        repeat (4) @(posedge clock_in);
        @(negedge clock_in);
        reset_in = 1'b1;
        @(posedge clock_in);
        #1;
        vectors++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || instr_ready_out !== 1'b0) begin
            $display("FAIL mid_reset: busy=%b done=%b ready=%b expected 0 0 0", busy_out, done_out, instr_ready_out);
            miscompares++;
        end
        @(negedge clock_in);
        reset_in = 1'b0;
        scalar("mid_c33", enc(10, 47, 0, 7), 8'd0);
        scalar("mid_c00", enc(10, 32, 0, 7), 8'd0);
        scalar("mid_b00", enc(10, 16, 0, 7), 8'd0);
        scalar("mid_regs", enc(13, 1, 2, 0), 8'd0);
    endtask

    task automatic test_range_nop;
        issue(enc(200, 8'h55, 0, 6));
        scalar("tload_oor_c33", enc(10, 47, 0, 7), 8'd0);
        scalar("li_marker", enc(15, 8'h77, 0, 4), 8'h77);
        scalar("tread_oor", enc(14, 200, 0, 7), 8'd0);
        scalar("li_marker2", enc(15, 8'h42, 0, 4), 8'h42);
        issue(enc(3, 1, 2, 8'hFF));
        vectors++;
        if (output_valid_out !== 1'b0 || cpu_output !== 8'h42 || busy_out !== 1'b0) begin
            $display("FAIL nop_ff: valid=%b cpu=%0h busy=%b expected 0 42 0", output_valid_out, cpu_output, busy_out);
            miscompares++;
        end
        scalar("nop_no_write", enc(12, 3, 0, 0), 8'd0);
    endtask

    initial begin
        test_reset;
        test_scalar;
        test_matmul;
        test_accumulate;
        test_back_to_back_hold;
        test_reset_mid_matmul;
        test_range_nop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
